test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter END_PC, default 32'h44, meaning the PC at which the test program has reached its result-check point.
REQ-002 SHALL have parameter TIMEOUT, default 5000, meaning the maximum RUN cycles before the test is declared hung.
REQ-003 SHALL have parameter PASS_GP, default 32'h1, meaning the x3 (gp) value that signals a pass.
REQ-004 Ports: clk  input  1  sole clock, all state on rising edge.
REQ-005 Ports: rst  input  1  reset, synchronous, active-low.
REQ-006 Ports: enable  input  1  starts monitoring when high in IDLE.
REQ-007 Ports: pc_valid  input  1  qualifies pc as a committed-instruction PC this cycle.
REQ-008 Ports: pc  input  32  core program counter.
REQ-009 Ports: gp  input  32  current core register x3.
REQ-010 Ports: done  output  1  test has concluded (pass, fail or timeout).
REQ-011 Ports: pass  output  1  concluded with gp == PASS_GP.
REQ-012 Ports: fail  output  1  concluded at END_PC with gp != PASS_GP.
REQ-013 Ports: timed_out  output  1  concluded by TIMEOUT expiry.
REQ-014 Ports: fail_test  output  31  latched gp[31:1], the failing test number.
REQ-015 Ports: cycle_count  output  32  RUN cycles elapsed, frozen at conclusion.
REQ-016 Ports: hist_idx  input  3  history read index, 0 = most recent PC.
REQ-017 Ports: hist_pc  output  32  history entry selected by hist_idx, combinational read.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, PASS, FAIL, TOUT.
REQ-019 IDLE -> RUN on the rising edge where enable == 1; cycle_count cleared on entry.
REQ-020 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at 32'hFFFFFFFF.
REQ-021 In RUN, pc_valid && pc == END_PC SHALL move to PASS if gp == PASS_GP, else FAIL, on the next edge.
REQ-022 On the FAIL transition, fail_test SHALL latch gp[31:1]; it is otherwise held.
REQ-023 In RUN, when cycle_count == TIMEOUT-1 with no END_PC match, SHALL move to TOUT.
REQ-024 END_PC match and timeout in the same cycle: the match wins (PASS/FAIL, never TOUT).
REQ-025 pc == END_PC with pc_valid == 0 SHALL be ignored.
REQ-026 done = state in {PASS, FAIL, TOUT}; pass/fail/timed_out are one-hot while done, all 0 otherwise.
REQ-027 PASS, FAIL and TOUT SHALL be sticky until reset; enable is ignored there.
REQ-028 Outputs are registered: done rises exactly one cycle after the deciding input is sampled.
REQ-029 enable dropping during RUN SHALL NOT stop monitoring.

Reset
REQ-030 When rst == 0 at a rising edge: state = IDLE, done/pass/fail/timed_out = 0, fail_test = 0, cycle_count = 0, history entries = 0.
REQ-031 Reset asserted mid-RUN SHALL abandon the run with no result reported.

Configuration
REQ-032 Macro TEST_MONITOR_HIST_EN defined: an 8-entry ring of the last pc values with pc_valid == 1 in RUN, hist_pc returns entry hist_idx (0 = newest); entries never written read 0.
REQ-033 Macro TEST_MONITOR_HIST_EN undefined: no history storage, hist_pc tied to 32'h0, hist_idx unused.

Structure
REQ-034 Shared package test_monitor_pkg SHALL hold the FSM state encoding constants and the history depth (8) and index width (3).
REQ-035 History ring SHALL be sub-module pc_history (write pointer wraps 7 -> 0), instantiated only under TEST_MONITOR_HIST_EN.

Verification
REQ-036 enable=1, then pc_valid=1, pc=32'h44, gp=1 after 20 cycles -> next edge done=1, pass=1, cycle_count=21, held for 100 cycles.
REQ-037 pc_valid=1, pc=32'h44, gp=32'h7 -> fail=1, fail_test=3, pass=0, timed_out=0.
REQ-038 TIMEOUT=10, no END_PC match -> timed_out=1 and done=1 exactly 10 cycles after RUN entry, cycle_count=10.
REQ-039 TIMEOUT=10, END_PC match with gp=1 on the cycle count reaches 9 -> pass=1, timed_out=0.
REQ-040 rst=0 for one edge mid-RUN at cycle 5 -> all outputs 0, state IDLE; a subsequent enable restarts with cycle_count from 0.
REQ-041 With TEST_MONITOR_HIST_EN, valid PCs 0x0,0x4,...,0x24 (10 entries) -> hist_idx=0 gives 0x24, hist_idx=7 gives 0x8; pc=0x44 with pc_valid=0 -> no conclusion.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test_monitor block: FSM state encoding,
// PC history geometry and a small state-decode helper.
package test_monitor_pkg;

  // Monitor FSM states. Values are fixed so waveforms stay readable.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } monState_e;

  // PC history ring geometry.
  localparam int HIST_DEPTH = 8;
  localparam int HIST_IDX_W = 3;

  // True once the monitor has reached any terminal state.
  function automatic logic isConcluded(monState_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TOUT);
  endfunction

endpackage

// File: rtl/test_monitor_if.sv
// Core trace bus observed by test_monitor: committed-PC qualifier, the
// committed PC and the current value of register x3 (gp).
interface test_monitor_if;
  logic        pc_valid;
  logic [31:0] pc;
  logic [31:0] gp;

  // The core (or a bench standing in for it) drives the trace.
  modport master (output pc_valid, output pc, output gp);

  // The monitor only observes the trace.
  modport slave (input pc_valid, input pc, input gp);
endinterface

// File: rtl/test_monitor_pc_history.sv
// pc_history: 8-entry ring of the most recent committed PCs.
// Only instantiated by test_monitor when TEST_MONITOR_HIST_EN is defined.
// Read index 0 returns the newest entry; entries never written read 0.
module pc_history
  import test_monitor_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [31:0]           wr_pc_i,
  input  logic [HIST_IDX_W-1:0] rd_idx_i,
  output logic [31:0]           rd_pc_o
);

  logic [31:0]           mem_q [HIST_DEPTH];
  logic [HIST_IDX_W-1:0] wrPtr_q;
  logic [HIST_IDX_W-1:0] rdAddr;

  // Store each qualified PC at the write pointer; the pointer is exactly
  // HIST_IDX_W bits wide so it wraps from 7 back to 0 on its own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wrPtr_q] <= wr_pc_i;
      wrPtr_q        <= wrPtr_q + HIST_IDX_W'(1);
    end
  end

  // Newest entry sits just behind the write pointer; older ones further back.
  always_comb begin
    rdAddr  = wrPtr_q - HIST_IDX_W'(1) - rd_idx_i;
    rd_pc_o = mem_q[rdAddr];
  end

endmodule

// File: rtl/test_monitor.sv
// test_monitor: watches a core's committed-PC trace and decides whether a
// self-checking test program passed, failed or hung.
// Optional feature macro: TEST_MONITOR_HIST_EN adds a ring of the last
// eight committed PCs readable through hist_idx/hist_pc; without it
// hist_pc reads 0 and hist_idx is ignored.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] END_PC  = 32'h44,
  parameter int          TIMEOUT = 5000,
  parameter logic [31:0] PASS_GP = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  test_monitor_if.slave         core,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timed_out,
  output logic [30:0]           fail_test,
  output logic [31:0]           cycle_count,
  input  logic [HIST_IDX_W-1:0] hist_idx,
  output logic [31:0]           hist_pc
);

  // Count value sampled on the last RUN cycle before the test is hung.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  monState_e   state_q, state_d;
  logic [30:0] failTest_q, failTest_d;
  logic [31:0] cycleCount_q, cycleCount_d;
  logic        endMatch;
  logic        histWr;

  assign endMatch = core.pc_valid && (core.pc == END_PC);
  assign histWr   = (state_q == ST_RUN) && core.pc_valid;

  // State, latched failing test number and RUN cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      failTest_q   <= '0;
      cycleCount_q <= '0;
    end else begin
      state_q      <= state_d;
      failTest_q   <= failTest_d;
      cycleCount_q <= cycleCount_d;
    end
  end

  // Next-state logic: an END_PC hit outranks the timeout on the same cycle,
  // and terminal states hold until reset regardless of enable.
  always_comb begin
    state_d      = state_q;
    failTest_d   = failTest_q;
    cycleCount_d = cycleCount_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_RUN;
          cycleCount_d = '0;
        end
      end
      ST_RUN: begin
        if (cycleCount_q != 32'hFFFF_FFFF) begin
          cycleCount_d = cycleCount_q + 32'd1;
        end
        if (endMatch) begin
          if (core.gp == PASS_GP) begin
            state_d = ST_PASS;
          end else begin
            state_d    = ST_FAIL;
            failTest_d = core.gp[31:1];
          end
        end else if (cycleCount_q == TIMEOUT_LAST) begin
          state_d = ST_TOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result flags decode straight from the registered state, so they are
  // one-hot while concluded and all low otherwise.
  always_comb begin
    done      = isConcluded(state_q);
    pass      = (state_q == ST_PASS);
    fail      = (state_q == ST_FAIL);
    timed_out = (state_q == ST_TOUT);
  end

  assign fail_test   = failTest_q;
  assign cycle_count = cycleCount_q;

`ifdef TEST_MONITOR_HIST_EN
  pc_history u_pc_history (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (histWr),
    .wr_pc_i  (core.pc),
    .rd_idx_i (hist_idx),
    .rd_pc_o  (hist_pc)
  );
`else
  logic unusedHist;
  assign unusedHist = (^hist_idx) ^ histWr;
  assign hist_pc    = 32'h0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor. Two instances share one stimulus stream: dutA
// uses the default TIMEOUT, dutB uses TIMEOUT=10. Expected conclusions are
// queued per instance when stimulus is driven and checked when done rises.
module tb_test_monitor;

`ifdef TEST_MONITOR_HIST_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pcValid;
  logic [31:0] pc;
  logic [31:0] gp;
  logic [2:0]  histIdx;

  logic        doneA, passA, failA, toutA;
  logic [30:0] failTestA;
  logic [31:0] countA, histA;
  logic        doneB, passB, failB, toutB;
  logic [30:0] failTestB;
  logic [31:0] countB, histB;

  typedef struct {
    int          edgeNum;
    logic        p;
    logic        f;
    logic        t;
    logic [30:0] ft;
    logic [31:0] cnt;
  } expect_t;

  expect_t qA[$];
  expect_t qB[$];

  int   checks = 0;
  int   failures = 0;
  int   tick = 0;
  int   startTick = 0;
  logic prevDoneA = 1'b0;
  logic prevDoneB = 1'b0;

  test_monitor_if busA ();
  test_monitor_if busB ();

  assign busA.pc_valid = pcValid;
  assign busA.pc       = pc;
  assign busA.gp       = gp;
  assign busB.pc_valid = pcValid;
  assign busB.pc       = pc;
  assign busB.gp       = gp;

  test_monitor dutA (
    .clk(clk), .rst(rst), .enable(enable), .core(busA),
    .done(doneA), .pass(passA), .fail(failA), .timed_out(toutA),
    .fail_test(failTestA), .cycle_count(countA),
    .hist_idx(histIdx), .hist_pc(histA)
  );

  test_monitor #(.TIMEOUT(10)) dutB (
    .clk(clk), .rst(rst), .enable(enable), .core(busB),
    .done(doneB), .pass(passB), .fail(failB), .timed_out(toutB),
    .fail_test(failTestB), .cycle_count(countB),
    .hist_idx(histIdx), .hist_pc(histB)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time conclusions relative to RUN entry.
  always @(posedge clk) tick <= tick + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkConclusion(input string who, input expect_t e, input int runEdge,
                                 input logic p, input logic f, input logic t,
                                 input logic [30:0] ft, input logic [31:0] cnt);
    checkOutput({who, " done edge"}, 32'(runEdge), 32'(e.edgeNum));
    checkOutput({who, " pass"}, 32'(p), 32'(e.p));
    checkOutput({who, " fail"}, 32'(f), 32'(e.f));
    checkOutput({who, " timed_out"}, 32'(t), 32'(e.t));
    checkOutput({who, " fail_test"}, 32'(ft), 32'(e.ft));
    checkOutput({who, " cycle_count"}, cnt, e.cnt);
  endtask

  task automatic checkQuiet(input string who, input logic d, input logic p, input logic f,
                            input logic t, input logic [30:0] ft, input logic [31:0] cnt);
    checkOutput({who, " done idle"}, 32'(d), 32'd0);
    checkOutput({who, " pass idle"}, 32'(p), 32'd0);
    checkOutput({who, " fail idle"}, 32'(f), 32'd0);
    checkOutput({who, " tout idle"}, 32'(t), 32'd0);
    checkOutput({who, " fail_test idle"}, 32'(ft), 32'd0);
    checkOutput({who, " count idle"}, cnt, 32'd0);
  endtask

  function automatic expect_t mkExp(input int n, input logic p, input logic f, input logic t,
                                    input logic [30:0] ft, input logic [31:0] cnt);
    expect_t e;
    e.edgeNum = n;
    e.p = p;
    e.f = f;
    e.t = t;
    e.ft = ft;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic logic [31:0] histExp(input logic [31:0] v);
    return HIST_ON ? v : 32'h0;
  endfunction

  // Pop and check an expectation whenever either instance concludes.
  always @(negedge clk) begin
    if (doneA && !prevDoneA) begin
      if (qA.size() == 0) checkOutput("A unexpected done", 32'(doneA), 32'd0);
      else checkConclusion("A", qA.pop_front(), tick - startTick,
                           passA, failA, toutA, failTestA, countA);
    end
    if (doneB && !prevDoneB) begin
      if (qB.size() == 0) checkOutput("B unexpected done", 32'(doneB), 32'd0);
      else checkConclusion("B", qB.pop_front(), tick - startTick,
                           passB, failB, toutB, failTestB, countB);
    end
    prevDoneA <= doneA;
    prevDoneB <= doneB;
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p, input logic [31:0] g);
    pcValid = v;
    pc      = p;
    gp      = g;
  endtask

  task automatic doReset();
    rst = 1'b0;
    enable = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    waitEdges(1);
    rst = 1'b1;
  endtask

  // Enable is held for a single edge only, so monitoring must continue
  // after it drops.
  task automatic startRun();
    enable = 1'b1;
    waitEdges(1);
    enable = 1'b0;
    startTick = tick;
  endtask

  task automatic endScenario(input string name);
    waitEdges(2);
    checkOutput({name, " A pending"}, 32'(qA.size()), 32'd0);
    checkOutput({name, " B pending"}, 32'(qB.size()), 32'd0);
    qA.delete();
    qB.delete();
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    histIdx = 3'd0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    waitEdges(2);
    rst = 1'b1;

    // Reset state and IDLE hold.
    checkQuiet("A reset", doneA, passA, failA, toutA, failTestA, countA);
    checkQuiet("B reset", doneB, passB, failB, toutB, failTestB, countB);
    checkOutput("A hist reset", histA, 32'h0);
    waitEdges(3);
    checkQuiet("A idle", doneA, passA, failA, toutA, failTestA, countA);

    // Pass after 20 cycles; dutB hangs at its 10-cycle timeout first.
    doReset();
    qA.push_back(mkExp(21, 1'b1, 1'b0, 1'b0, 31'd0, 32'd21));
    qB.push_back(mkExp(10, 1'b0, 1'b0, 1'b1, 31'd0, 32'd10));
    startRun();
    waitEdges(20);
    applyStimulus(1'b1, 32'h44, 32'h1);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    waitEdges(50);
    enable = 1'b1;
    applyStimulus(1'b1, 32'h44, 32'h7);
    waitEdges(1);
    enable = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    waitEdges(49);
    checkOutput("A pass held", 32'({doneA, passA, failA, toutA}), 32'b1100);
    checkOutput("A count frozen", countA, 32'd21);
    checkOutput("A fail_test held", 32'(failTestA), 32'd0);
    checkOutput("B tout held", 32'({doneB, passB, failB, toutB}), 32'b1001);
    checkOutput("B count frozen", countB, 32'd10);
    endScenario("pass");

    // Fail with gp=7 reports test 3.
    doReset();
    qA.push_back(mkExp(5, 1'b0, 1'b1, 1'b0, 31'd3, 32'd5));
    qB.push_back(mkExp(5, 1'b0, 1'b1, 1'b0, 31'd3, 32'd5));
    startRun();
    waitEdges(4);
    applyStimulus(1'b1, 32'h44, 32'h7);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    histIdx = 3'd0;
    #1;
    checkOutput("A hist newest after fail", histA, histExp(32'h44));
    histIdx = 3'd1;
    #1;
    checkOutput("A hist unwritten", histA, 32'h0);
    histIdx = 3'd0;
    endScenario("fail");

    // dutB times out at 10 cycles; dutA passes later at cycle 15.
    doReset();
    qB.push_back(mkExp(10, 1'b0, 1'b0, 1'b1, 31'd0, 32'd10));
    qA.push_back(mkExp(15, 1'b1, 1'b0, 1'b0, 31'd0, 32'd15));
    startRun();
    waitEdges(14);
    checkOutput("B count after timeout", countB, 32'd10);
    applyStimulus(1'b1, 32'h44, 32'h1);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    endScenario("timeout");

    // END_PC match on the timeout cycle: the match wins.
    doReset();
    qA.push_back(mkExp(10, 1'b1, 1'b0, 1'b0, 31'd0, 32'd10));
    qB.push_back(mkExp(10, 1'b1, 1'b0, 1'b0, 31'd0, 32'd10));
    startRun();
    waitEdges(9);
    applyStimulus(1'b1, 32'h44, 32'h1);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    endScenario("match vs timeout");

    // Reset mid-RUN abandons the run; a new enable restarts from zero.
    doReset();
    startRun();
    waitEdges(4);
    rst = 1'b0;
    waitEdges(1);
    rst = 1'b1;
    checkQuiet("A midreset", doneA, passA, failA, toutA, failTestA, countA);
    checkQuiet("B midreset", doneB, passB, failB, toutB, failTestB, countB);
    waitEdges(3);
    checkQuiet("A after midreset", doneA, passA, failA, toutA, failTestA, countA);
    qA.push_back(mkExp(3, 1'b0, 1'b1, 1'b0, 31'd1, 32'd3));
    qB.push_back(mkExp(3, 1'b0, 1'b1, 1'b0, 31'd1, 32'd3));
    startRun();
    checkOutput("A restart count", countA, 32'd0);
    waitEdges(2);
    checkOutput("A count 2", countA, 32'd2);
    checkOutput("B count 2", countB, 32'd2);
    applyStimulus(1'b1, 32'h44, 32'h2);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    endScenario("midreset");

    // History ring and invalid END_PC presentation.
    doReset();
    qB.push_back(mkExp(10, 1'b0, 1'b0, 1'b1, 31'd0, 32'd10));
    qA.push_back(mkExp(14, 1'b1, 1'b0, 1'b0, 31'd0, 32'd14));
    startRun();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 32'h0);
      waitEdges(1);
    end
    applyStimulus(1'b0, 32'h44, 32'h1);
    waitEdges(3);
    checkOutput("A invalid END_PC ignored", 32'(doneA), 32'd0);
    histIdx = 3'd0;
    #1;
    checkOutput("A hist idx0", histA, histExp(32'h24));
    checkOutput("B hist idx0", histB, histExp(32'h24));
    histIdx = 3'd1;
    #1;
    checkOutput("A hist idx1", histA, histExp(32'h20));
    histIdx = 3'd7;
    #1;
    checkOutput("A hist idx7", histA, histExp(32'h8));
    checkOutput("B hist idx7", histB, histExp(32'h8));
    histIdx = 3'd0;
    applyStimulus(1'b1, 32'h44, 32'h1);
    waitEdges(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    endScenario("history");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
